// File: rtl/fix_tv_extractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : fix_tv_extractor_if
//  Description : Byte-stream input and record-output bundle for
//                fix_tv_extractor.
//                master : stream producer / record consumer side.
//                slave  : extractor side.
//                Input stream : in_data, in_valid, in_ready.
//                Output record: out_valid, out_ready, tag_o, value_o, len_o,
//                               start_of_header_o, end_of_body_o, err_o,
//                               cks_err_o, level_o.
//  Revision    : 1.0  initial release
// ============================================================================
interface fix_tv_extractor_if #(
    parameter int TAG_W     = 32,
    parameter int VAL_BYTES = 32,
    parameter int DEPTH     = 4
);
    localparam int LEN_W = $clog2(VAL_BYTES + 1);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [TAG_W-1:0]       tag_o;
    logic [8*VAL_BYTES-1:0] value_o;
    logic [LEN_W-1:0]       len_o;
    logic                   start_of_header_o;
    logic                   end_of_body_o;
    logic                   err_o;
    logic                   cks_err_o;
    logic [LVL_W-1:0]       level_o;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid, tag_o, value_o, len_o,
               start_of_header_o, end_of_body_o, err_o, cks_err_o, level_o
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid, tag_o, value_o, len_o,
               start_of_header_o, end_of_body_o, err_o, cks_err_o, level_o
    );
endinterface
`default_nettype wire

// File: rtl/fix_tv_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : fix_tv_extractor
//  Description : Parses a raw FIX byte stream into tag/value records
//                (binary tag, right-aligned value, length, flags) and queues
//                them in an output FIFO.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - fix_tv_extractor_if.slave (byte stream in, records out)
//  Options     : FIX_CHECKSUM_EN - enables the FIX checksum check on the
//                tag-10 record (cks_err_o); otherwise cks_err_o is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module fix_tv_extractor #(
    parameter int TAG_W          = 32,
    parameter int MAX_TAG_DIGITS = 6,
    parameter int VAL_BYTES      = 32,
    parameter int DEPTH          = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fix_tv_extractor_if.slave bus
);
    localparam int LEN_W  = $clog2(VAL_BYTES + 1);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int VAL_W  = 8 * VAL_BYTES;
    localparam int NDIG_W = $clog2(MAX_TAG_DIGITS + 1);
    localparam logic [7:0] C_SOH = 8'h01;
    localparam logic [7:0] C_EQ  = 8'h3D;

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_VALUE, S_DISCARD} state_t;

    typedef struct packed {
        logic             cks;
        logic             err;
        logic             eob;
        logic             soh;
        logic [LEN_W-1:0] len;
        logic [VAL_W-1:0] value;
        logic [TAG_W-1:0] tag;
    } rec_t;

    // Parser state
    state_t            r_state, w_state_nxt;
    logic [TAG_W-1:0]  r_tag, w_tag_nxt;
    logic [NDIG_W-1:0] r_ndig, w_ndig_nxt;
    logic [VAL_W-1:0]  r_value, w_value_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    logic              r_err, w_err_nxt;
    logic              w_push, w_rec_err, w_rec_cks;
    rec_t              w_rec;

    // FIFO state
    rec_t              r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]  r_count, w_count_nxt;
    logic              r_in_ready;
    logic              w_out_valid, w_pop;
    rec_t              w_head;

    logic w_accept, w_is_digit, w_is_soh, w_is_eq;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    assign w_is_soh   = (bus.in_data == C_SOH);
    assign w_is_eq    = (bus.in_data == C_EQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tag   <= '0;
            r_ndig  <= '0;
            r_value <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= w_tag_nxt;
            r_ndig  <= w_ndig_nxt;
            r_value <= w_value_nxt;
            r_len   <= w_len_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tag_nxt   = r_tag;
        w_ndig_nxt  = r_ndig;
        w_value_nxt = r_value;
        w_len_nxt   = r_len;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_rec_err   = r_err;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_tag_nxt   = TAG_W'(bus.in_data[3:0]);
                        w_ndig_nxt  = NDIG_W'(1);
                        w_state_nxt = S_TAG;
                    end else if (!w_is_soh) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end
                end
                S_TAG: begin
                    if (w_is_digit) begin
                        if (r_ndig == NDIG_W'(MAX_TAG_DIGITS)) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_DISCARD;
                        end else begin
                            w_tag_nxt  = r_tag * TAG_W'(10) + TAG_W'(bus.in_data[3:0]);
                            w_ndig_nxt = r_ndig + NDIG_W'(1);
                        end
                    end else if (w_is_eq) begin
                        w_value_nxt = '0;
                        w_len_nxt   = '0;
                        w_state_nxt = S_VALUE;
                    end else if (w_is_soh) begin
                        // Tag cut short by SOH: emit it flagged rather than drop it.
                        w_rec_err   = 1'b1;
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end
                end
                S_VALUE: begin
                    if (w_is_soh) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_len < LEN_W'(VAL_BYTES)) begin
                        w_value_nxt = {r_value[VAL_W-9:0], bus.in_data};
                        w_len_nxt   = r_len + LEN_W'(1);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: begin
                    if (w_is_soh) begin
                        w_rec_err   = 1'b1;
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
            // Every record starts from a clean accumulator set.
            if (w_push) begin
                w_tag_nxt   = '0;
                w_ndig_nxt  = '0;
                w_value_nxt = '0;
                w_len_nxt   = '0;
                w_err_nxt   = 1'b0;
            end
        end
    end

`ifdef FIX_CHECKSUM_EN
    // r_sum      : running sum, restarted by the tag-8 pair.
    // r_pair_sum : sum of the current pair's bytes so far (needed because the
    //              pair is only known to be tag 8 once '=' arrives).
    // r_ref_sum  : r_sum as it stood before the current pair began.
    logic [7:0] r_sum, r_pair_sum, r_ref_sum;
    logic [7:0] w_d2, w_d1, w_d0;
    logic [9:0] w_cks_val;
    logic       w_cks_fmt_ok;

    function automatic logic f_is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum      <= '0;
            r_pair_sum <= '0;
            r_ref_sum  <= '0;
        end else if (w_accept) begin
            if (r_state == S_TAG && w_is_eq && r_tag == TAG_W'(8))
                r_sum <= r_pair_sum + bus.in_data;
            else
                r_sum <= r_sum + bus.in_data;
            if (r_state == S_IDLE && !w_is_soh) begin
                r_ref_sum  <= r_sum;
                r_pair_sum <= bus.in_data;
            end else begin
                r_pair_sum <= r_pair_sum + bus.in_data;
            end
        end
    end

    assign w_d2         = r_value[23:16];
    assign w_d1         = r_value[15:8];
    assign w_d0         = r_value[7:0];
    assign w_cks_fmt_ok = (r_len == LEN_W'(3)) && f_is_digit(w_d2)
                          && f_is_digit(w_d1) && f_is_digit(w_d0);
    assign w_cks_val    = 10'(w_d2[3:0]) * 10'd100 + 10'(w_d1[3:0]) * 10'd10
                          + 10'(w_d0[3:0]);
    assign w_rec_cks    = (r_tag == TAG_W'(10))
                          && (!w_cks_fmt_ok || (w_cks_val != {2'b00, r_ref_sum}));
`else
    assign w_rec_cks = 1'b0;
`endif

    assign w_rec = '{cks:   w_rec_cks,
                     err:   w_rec_err,
                     eob:   (r_tag == TAG_W'(10)) && !w_rec_err,
                     soh:   (r_tag == TAG_W'(8)) && !w_rec_err,
                     len:   r_len,
                     value: r_value,
                     tag:   r_tag};

    // Output FIFO: no fall-through, head visible the cycle after the write.
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_count_nxt = r_count + LVL_W'(w_push) - LVL_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_rec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_nxt;
            // Registered from occupancy only, so a full FIFO never accepts a byte.
            r_in_ready <= (w_count_nxt != LVL_W'(DEPTH));
        end
    end

    // Gating with out_valid keeps every head field at 0 while empty/in reset.
    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.in_ready          = r_in_ready;
    assign bus.out_valid         = w_out_valid;
    assign bus.tag_o             = w_head.tag;
    assign bus.value_o           = w_head.value;
    assign bus.len_o             = w_head.len;
    assign bus.start_of_header_o = w_head.soh;
    assign bus.end_of_body_o     = w_head.eob;
    assign bus.err_o             = w_head.err;
    assign bus.cks_err_o         = w_head.cks;
    assign bus.level_o           = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fix_tv_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fix_tv_extractor
//  Description : Directed self-checking bench for fix_tv_extractor.
//                In stimulus strings '|' stands for SOH (0x01).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fix_tv_extractor;
    localparam int TAG_W = 32, VAL_BYTES = 32, DEPTH = 4, MAXD = 6;

    typedef struct packed {
        logic [31:0]  tag;
        logic [255:0] value;
        logic [5:0]   len;
        logic         soh, eob, err, cks;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    rec_t q[$];

    always #5 clk = ~clk;

    fix_tv_extractor_if #(.TAG_W(TAG_W), .VAL_BYTES(VAL_BYTES), .DEPTH(DEPTH)) bus ();

    fix_tv_extractor #(
        .TAG_W(TAG_W), .MAX_TAG_DIGITS(MAXD), .VAL_BYTES(VAL_BYTES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Handshake is stable between negedge and the next posedge, so a head seen
    // here with out_ready high is the one consumed at the coming edge.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready)
            q.push_back('{tag: bus.tag_o, value: bus.value_o, len: bus.len_o,
                          soh: bus.start_of_header_o, eob: bus.end_of_body_o,
                          err: bus.err_o, cks: bus.cks_err_o});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout: in_ready stuck at %0b, need 1", bus.in_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte((s[i] == "|") ? 8'h01 : s[i]);
    endtask

    task automatic wait_recs(input int n);
        int t = 0;
        while (q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() < n) begin
            n_vec++; n_bad++;
            $display("FAIL wait_recs: got %0d records, need %0d", q.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset.out_valid got %0b need 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset.in_ready got %0b need 1", bus.in_ready); end
        n_vec++; if (bus.level_o !== '0) begin n_bad++; $display("FAIL reset.level got %0d need 0", bus.level_o); end
        n_vec++; if ({bus.tag_o, bus.len_o, bus.err_o, bus.cks_err_o, bus.start_of_header_o, bus.end_of_body_o} !== '0 || bus.value_o !== '0)
            begin n_bad++; $display("FAIL reset.fields got tag %0h len %0d err %0b, need all 0", bus.tag_o, bus.len_o, bus.err_o); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset.release got ready %0b valid %0b need 1/0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_basic();
        rec_t r;
        bus.out_ready = 1'b1;
        send_str("8=FIX.4.2");
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic.pre_valid got %0b need 0", bus.out_valid); end
        send_byte(8'h01);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic.latency got out_valid %0b need 1", bus.out_valid); end
        wait_recs(1);
        if (q.size() >= 1) begin
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd8) begin n_bad++; $display("FAIL basic.tag got %0d need 8", r.tag); end
            n_vec++; if (r.len !== 6'd7) begin n_bad++; $display("FAIL basic.len got %0d need 7", r.len); end
            n_vec++; if (r.value !== 256'h4649582E342E32) begin n_bad++; $display("FAIL basic.value got %0h need 4649582e342e32", r.value); end
            n_vec++; if ({r.soh, r.eob, r.err, r.cks} !== 4'b1000) begin n_bad++; $display("FAIL basic.flags got soh/eob/err/cks %b need 1000", {r.soh, r.eob, r.err, r.cks}); end
        end
    endtask

    task automatic test_two_pairs();
        rec_t r;
        send_str("35=D|10=000|");
        wait_recs(2);
        if (q.size() >= 2) begin
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd35 || r.value !== 256'h44 || r.len !== 6'd1) begin n_bad++; $display("FAIL pair35 got tag %0d val %0h len %0d need 35/44/1", r.tag, r.value, r.len); end
            n_vec++; if ({r.soh, r.eob, r.err} !== 3'b000) begin n_bad++; $display("FAIL pair35.flags got %b need 000", {r.soh, r.eob, r.err}); end
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd10 || r.value !== 256'h303030 || r.len !== 6'd3) begin n_bad++; $display("FAIL pair10 got tag %0d val %0h len %0d need 10/303030/3", r.tag, r.value, r.len); end
            n_vec++; if ({r.soh, r.eob, r.err} !== 3'b010) begin n_bad++; $display("FAIL pair10.flags got %b need 010", {r.soh, r.eob, r.err}); end
        end
    endtask

    task automatic test_tag_errors();
        rec_t r;
        send_str("1234567=X|55=A|");
        wait_recs(2);
        if (q.size() >= 2) begin
            r = q.pop_front();
            n_vec++; if (r.err !== 1'b1) begin n_bad++; $display("FAIL tag7digits.err got %0b need 1", r.err); end
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd55 || r.err !== 1'b0 || r.value !== 256'h41) begin n_bad++; $display("FAIL recover55 got tag %0d err %0b val %0h need 55/0/41", r.tag, r.err, r.value); end
        end
        // Non-digit from idle, empty value, SOH inside a tag, 6-digit tag edge.
        send_str("=x|9=|12|999999=Z|");
        wait_recs(4);
        if (q.size() >= 4) begin
            r = q.pop_front();
            n_vec++; if (r.err !== 1'b1 || r.soh !== 1'b0) begin n_bad++; $display("FAIL idle_junk got err %0b soh %0b need 1/0", r.err, r.soh); end
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd9 || r.len !== 6'd0 || r.value !== '0 || r.err !== 1'b0) begin n_bad++; $display("FAIL empty_val got tag %0d len %0d err %0b need 9/0/0", r.tag, r.len, r.err); end
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd12 || r.err !== 1'b1) begin n_bad++; $display("FAIL soh_in_tag got tag %0d err %0b need 12/1", r.tag, r.err); end
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd999999 || r.err !== 1'b0 || r.value !== 256'h5A) begin n_bad++; $display("FAIL tag6digits got tag %0d err %0b need 999999/0", r.tag, r.err); end
        end
    endtask

    task automatic test_long_value();
        rec_t r;
        logic [255:0] exp_v;
        send_str("7=");
        for (int i = 0; i < 40; i++) send_byte(8'h41 + 8'(i));
        send_byte(8'h01);
        for (int k = 0; k < 32; k++) exp_v[8*k +: 8] = 8'h41 + 8'(31 - k);
        wait_recs(1);
        if (q.size() >= 1) begin
            r = q.pop_front();
            n_vec++; if (r.len !== 6'd32 || r.err !== 1'b1 || r.tag !== 32'd7) begin n_bad++; $display("FAIL long.len_err got len %0d err %0b tag %0d need 32/1/7", r.len, r.err, r.tag); end
            n_vec++; if (r.value !== exp_v) begin n_bad++; $display("FAIL long.value got %0h need %0h", r.value, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        rec_t r;
        bus.out_ready = 1'b0;
        send_str("1=a|2=b|3=c|4=d|");
        n_vec++; if (bus.level_o !== 3'd4 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full got level %0d in_ready %0b need 4/0", bus.level_o, bus.in_ready); end
        n_vec++; if (bus.tag_o !== 32'd1 || bus.value_o !== 256'h61) begin n_bad++; $display("FAIL full.head got tag %0d val %0h need 1/61", bus.tag_o, bus.value_o); end
        fork
            send_str("5=e|");
            begin
                repeat (4) @(negedge clk);
                n_vec++; if (bus.level_o !== 3'd4 || q.size() != 0 || bus.tag_o !== 32'd1) begin n_bad++; $display("FAIL stall got level %0d recs %0d tag %0d need 4/0/1", bus.level_o, q.size(), bus.tag_o); end
                bus.out_ready = 1'b1;
            end
        join
        wait_recs(5);
        if (q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                r = q.pop_front();
                n_vec++; if (r.tag !== 32'(i + 1) || r.value !== 256'(8'h61 + 8'(i)) || r.err !== 1'b0)
                    begin n_bad++; $display("FAIL order[%0d] got tag %0d val %0h need %0d/%0h", i, r.tag, r.value, i + 1, 8'h61 + 8'(i)); end
            end
        end
        repeat (2) @(negedge clk);
        n_vec++; if (bus.level_o !== '0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL drained got level %0d in_ready %0b need 0/1", bus.level_o, bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        bus.out_ready = 1'b0;
        send_str("20=ab|21=xy");
        n_vec++; if (bus.level_o !== 3'd1) begin n_bad++; $display("FAIL pre_rst.level got %0d need 1", bus.level_o); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.level_o !== '0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst got valid %0b level %0d ready %0b need 0/0/1", bus.out_valid, bus.level_o, bus.in_ready); end
        n_vec++; if (bus.tag_o !== '0 || bus.value_o !== '0 || bus.len_o !== '0 || bus.err_o !== 1'b0) begin n_bad++; $display("FAIL async_rst.fields got tag %0d val %0h len %0d need 0", bus.tag_o, bus.value_o, bus.len_o); end
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        send_str("22=Q|");
        wait_recs(1);
        if (q.size() >= 1) begin
            r = q.pop_front();
            n_vec++; if (r.tag !== 32'd22 || r.value !== 256'h51 || r.len !== 6'd1 || r.err !== 1'b0) begin n_bad++; $display("FAIL post_rst got tag %0d val %0h len %0d err %0b need 22/51/1/0", r.tag, r.value, r.len, r.err); end
        end
        n_vec++; if (q.size() != 0) begin n_bad++; $display("FAIL post_rst.extra got %0d stray records need 0", q.size()); end
    endtask

    task automatic test_checksum();
        rec_t r;
        // Bytes before "10=" sum to 929; 929 mod 256 = 161.
        send_str("8=FIX.4.2|9=5|35=0|10=161|");
        wait_recs(4);
        if (q.size() >= 4) begin
            for (int i = 0; i < 3; i++) begin
                r = q.pop_front();
                n_vec++; if (r.cks !== 1'b0) begin n_bad++; $display("FAIL cks.body[%0d] got %0b need 0", i, r.cks); end
            end
            r = q.pop_front();
`ifdef FIX_CHECKSUM_EN
            n_vec++; if (r.tag !== 32'd10 || r.cks !== 1'b0 || r.eob !== 1'b1) begin n_bad++; $display("FAIL cks.good got tag %0d cks %0b eob %0b need 10/0/1", r.tag, r.cks, r.eob); end
`else
            n_vec++; if (r.tag !== 32'd10 || r.cks !== 1'b0 || r.eob !== 1'b1) begin n_bad++; $display("FAIL cks.off got tag %0d cks %0b eob %0b need 10/0/1", r.tag, r.cks, r.eob); end
`endif
        end
        send_str("8=FIX.4.2|9=5|35=0|10=162|");
        wait_recs(4);
        if (q.size() >= 4) begin
            repeat (3) void'(q.pop_front());
            r = q.pop_front();
`ifdef FIX_CHECKSUM_EN
            n_vec++; if (r.tag !== 32'd10 || r.cks !== 1'b1) begin n_bad++; $display("FAIL cks.bad got tag %0d cks %0b need 10/1", r.tag, r.cks); end
`else
            n_vec++; if (r.tag !== 32'd10 || r.cks !== 1'b0) begin n_bad++; $display("FAIL cks.off2 got tag %0d cks %0b need 10/0", r.tag, r.cks); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_pairs();
        test_tag_errors();
        test_long_value();
        test_back_to_back();
        test_reset_mid();
        test_checksum();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
